fetch_sequencer: RTL
====================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, 8'h00, fetch address loaded at reset.
REQ-002 Parameter HALT_OPCODE, 5'b11111, opcode field value (instr_in[18:14]) that stops fetch.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 run  input  1  start fetch from IDLE, resume from HALT.
REQ-006 redirect  input  1  branch/jump redirect strobe from execute.
REQ-007 redirect_addr  input  8  redirect target address.
REQ-008 pc  output  8  registered fetch address to instruction memory.
REQ-009 instr_in  input  19  instruction memory read data; combinational function of pc, same cycle.
REQ-010 ir  output  19  registered instruction to decode.
REQ-011 ir_pc  output  8  address of the instruction held in ir.
REQ-012 ir_valid  output  1  ir holds an instruction not yet accepted.
REQ-013 ir_ready  input  1  decode accepts ir this cycle when ir_valid=1.
REQ-014 halted  output  1  high exactly while in HALT state.

Function
REQ-015 States: IDLE, FETCH, HALT, 2-bit encoded; no other reachable state.
REQ-016 Slot free = !ir_valid || ir_ready; fetch occurs in FETCH only when slot free and redirect=0.
REQ-017 Fetch: ir<=instr_in, ir_pc<=pc, ir_valid<=1; latency one cycle from pc=A to ir=mem[A].
REQ-018 Fetch of non-halt instruction: pc<=pc+1, modulo 256 (8'hFF wraps to 8'h00), stay FETCH.
REQ-019 Fetch of instruction with instr_in[18:14]==HALT_OPCODE: loaded into ir normally, pc holds, next state HALT.
REQ-020 FETCH with ir_valid=1 and ir_ready=0 (stall): pc, ir, ir_pc, ir_valid, state all hold.
REQ-021 Slot free without fetch (IDLE, HALT, redirect): ir_valid<=0 if it was accepted, ir/ir_pc hold.
REQ-022 Redirect in FETCH or HALT: pc<=redirect_addr, ir_valid<=0 (flush, even if ir_ready=1 or stalled), next state FETCH; no fetch that cycle.
REQ-023 Redirect in IDLE: pc<=redirect_addr, ir_valid stays 0, state stays IDLE.
REQ-024 Redirect has priority over run, stall and halt detection in the same cycle.
REQ-025 IDLE with run=1 and redirect=0: next state FETCH, pc unchanged; first fetch in the following cycle.
REQ-026 HALT: no fetch; ir drains via ir_ready; run=1 (redirect=0) -> pc<=pc+1, next state FETCH.
REQ-027 run in FETCH has no effect.
REQ-028 ir_valid never rises without a fetch; each fetched word presented exactly once unless flushed.

Reset
REQ-029 rst_n=0 at a clock edge: state<=IDLE, pc<=RESET_PC, ir<=0, ir_pc<=0, ir_valid<=0, halted<=0; overrides all inputs.
REQ-030 Reset mid-operation (any state, stalled or not) discards ir contents; no instruction presented after reset until run.
REQ-031 Outputs undefined only before the first reset edge; no asynchronous path from rst_n.

Verification
REQ-032 Reset then run=1, ir_ready=1, mem[0..2]=19'h0A008,19'h00001,19'h7C000 -> ir_valid from cycle 2; ir_pc 0,1,2; halted=1 after mem[2]; pc stays 2.
REQ-033 Stall: ir_ready=0 for 3 cycles while ir_valid=1 -> pc, ir, ir_pc constant; ir_ready=1 -> next word follows with no loss or duplication.
REQ-034 Redirect to 8'h40 while ir_valid=1, ir_ready=0 -> next cycle ir_valid=0, pc=8'h40; following cycle ir_pc=8'h40.
REQ-035 Start at RESET_PC=8'hFE with non-halt words -> ir_pc sequence FE, FF, 00, 01.
REQ-036 In HALT at pc=8'h05: run=1 -> FETCH, ir_pc next 8'h06; run=1 and redirect=1 (addr 8'h10) same cycle -> ir_pc next 8'h10.
REQ-037 rst_n=0 during stall in FETCH -> next cycle IDLE, pc=RESET_PC, ir_valid=0, halted=0; run ignored while rst_n=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: IDLE/FETCH/HALT control of pc and the single ir slot to decode.
// One cycle from pc=A to ir=mem[A]; ir holds under ir_ready=0 and redirect flushes it.
module fetch_sequencer #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter logic [4:0] HALT_OPCODE = 5'b11111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        redirect,
    input  logic [7:0]  redirect_addr,
    output logic [7:0]  pc,
    input  logic [18:0] instr_in,
    output logic [18:0] ir,
    output logic [7:0]  ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic        halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HALT  = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [18:0] ir_q, ir_d;
    logic [7:0]  ir_pc_q, ir_pc_d;
    logic        ir_valid_q, ir_valid_d;
    logic        halted_q, halted_d;
    logic        slot_free;
    logic        is_halt;

    assign slot_free = !ir_valid_q || ir_ready;
    assign is_halt   = (instr_in[18:14] == HALT_OPCODE);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        // An accepted word leaves the slot; a stalled one stays put.
        ir_valid_d = ir_valid_q && !ir_ready;

        case (state_q)
            IDLE: begin
                if (redirect) begin
                    pc_d = redirect_addr;
                end else if (run) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (redirect) begin
                    pc_d       = redirect_addr;
                    ir_valid_d = 1'b0;
                end else if (slot_free) begin
                    ir_d       = instr_in;
                    ir_pc_d    = pc_q;
                    ir_valid_d = 1'b1;
                    if (is_halt) begin
                        state_d = HALT;
                    end else begin
                        pc_d = pc_q + 8'd1;
                    end
                end
            end
            HALT: begin
                if (redirect) begin
                    pc_d       = redirect_addr;
                    ir_valid_d = 1'b0;
                    state_d    = FETCH;
                end else if (run) begin
                    pc_d    = pc_q + 8'd1;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d    = IDLE;
                ir_valid_d = 1'b0;
            end
        endcase

        halted_d = (state_d == HALT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
        end
    end

    assign pc       = pc_q;
    assign ir       = ir_q;
    assign ir_pc    = ir_pc_q;
    assign ir_valid = ir_valid_q;
    assign halted   = halted_q;

endmodule
